// File: rtl/instr_aligner.sv
// Halfword instruction aligner between icache and fetch; stitches word-straddling 32-bit instructions.
// Optional feature: define ALIGNER_ILLEGAL_CHK_EN to flag the all-zero compressed parcel as illegal.
module instr_aligner #(
    parameter int          XLEN      = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instr_un,
    input  logic [XLEN-1:0] pc_ff,
    input  logic            icache_valid,
    input  logic            kill,
    output logic [31:0]     instr,
    output logic            is_comp,
    output logic            instr_valid,
    output logic            stall,
    output logic [XLEN-1:0] pc_aligned,
    output logic            illegal
);

    typedef enum logic {
        IDLE,
        SPLIT_WAIT
    } state_e;

    localparam logic [XLEN-1:0] HALF_STEP = XLEN'(2);

    state_e          state_q, state_d;
    logic [15:0]     hold_half_q, hold_half_d;
    logic [XLEN-1:0] hold_pc_q, hold_pc_d;
    logic [15:0]     par;
    logic [XLEN-1:0] next_half_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_half_q <= 16'h0000;
            hold_pc_q   <= '0;
        end else begin
            state_q     <= state_d;
            hold_half_q <= hold_half_d;
            hold_pc_q   <= hold_pc_q == hold_pc_d ? hold_pc_q : hold_pc_d;
        end
    end

    assign par          = pc_ff[1] ? instr_un[31:16] : instr_un[15:0];
    assign next_half_pc = hold_pc_q + HALF_STEP;

    always_comb begin
        state_d     = state_q;
        hold_half_d = hold_half_q;
        hold_pc_d   = hold_pc_q;
        instr       = NOP_INSTR;
        is_comp     = 1'b0;
        instr_valid = 1'b0;
        stall       = 1'b0;
        pc_aligned  = {pc_ff[XLEN-1:2], 2'b00};

        unique case (state_q)
            IDLE: begin
                if (icache_valid) begin
                    if (par[1:0] != 2'b11) begin
                        instr       = {16'h0000, par};
                        is_comp     = 1'b1;
                        instr_valid = 1'b1;
                    end else if (!pc_ff[1]) begin
                        instr       = instr_un;
                        instr_valid = 1'b1;
                    end else begin
                        // Upper half begins a 32-bit instruction; keep it and fetch the next word.
                        hold_half_d = instr_un[31:16];
                        hold_pc_d   = pc_ff;
                        stall       = 1'b1;
                        pc_aligned  = pc_ff + HALF_STEP;
                        state_d     = SPLIT_WAIT;
                    end
                end
            end
            SPLIT_WAIT: begin
                stall      = 1'b1;
                pc_aligned = {next_half_pc[XLEN-1:2], 2'b00};
                if (icache_valid) begin
                    instr       = {instr_un[15:0], hold_half_q};
                    instr_valid = 1'b1;
                    stall       = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A redirect discards whatever is in flight, including a half-built instruction.
        if (kill) begin
            instr       = NOP_INSTR;
            is_comp     = 1'b0;
            instr_valid = 1'b0;
            stall       = 1'b0;
            state_d     = IDLE;
            hold_half_d = 16'h0000;
        end
    end

`ifdef ALIGNER_ILLEGAL_CHK_EN
    assign illegal = is_comp && (instr[15:0] == 16'h0000);
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_instr_aligner.sv
// Self-checking bench for instr_aligner: directed cycle table, mid-split reset, then random traffic
// compared against a behavioural model of parcel selection and split stitching.
module tb_instr_aligner;

    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef ALIGNER_ILLEGAL_CHK_EN
    localparam logic ILL_EN = 1'b1;
`else
    localparam logic ILL_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
        logic        v;
        logic        k;
        logic [31:0] eInstr;
        logic        eComp;
        logic        eValid;
        logic        eStall;
        logic [31:0] ePcal;
        logic        eIll;
        logic        chkPcal;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic        comp;
        logic        valid;
        logic        stall;
        logic [31:0] pcal;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instrUn;
    logic [31:0] pcFf;
    logic        icacheValid;
    logic        kill;
    logic [31:0] instr;
    logic        isComp;
    logic        instrValid;
    logic        stall;
    logic [31:0] pcAligned;
    logic        illegal;

    int checks   = 0;
    int failures = 0;

    // Model state: a held upper half waiting for its partner word.
    logic        mHave;
    logic [15:0] mHalf;
    logic [31:0] mPc;

    vec_t vecs[20];

    instr_aligner #(.XLEN(32), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .instr_un(instrUn), .pc_ff(pcFf),
        .icache_valid(icacheValid), .kill(kill), .instr(instr), .is_comp(isComp),
        .instr_valid(instrValid), .stall(stall), .pc_aligned(pcAligned), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] word,
                                 input logic v, input logic k);
        pcFf        = pc;
        instrUn     = word;
        icacheValid = v;
        kill        = k;
        #2;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic checkAll(input string tag, input exp_t e, input logic doPcal);
        checkOutput({tag, ".instr"}, instr, e.instr);
        checkOutput({tag, ".is_comp"}, {31'b0, isComp}, {31'b0, e.comp});
        checkOutput({tag, ".instr_valid"}, {31'b0, instrValid}, {31'b0, e.valid});
        checkOutput({tag, ".stall"}, {31'b0, stall}, {31'b0, e.stall});
        checkOutput({tag, ".illegal"}, {31'b0, illegal}, {31'b0, e.ill});
        if (doPcal) checkOutput({tag, ".pc_aligned"}, pcAligned, e.pcal);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs computed directly from the parcel/split rules.
    function automatic exp_t refModel(input logic [31:0] pc, input logic [31:0] word,
                                      input logic v, input logic k);
        exp_t        e;
        logic [15:0] p;
        e.instr = NOP; e.comp = 1'b0; e.valid = 1'b0; e.stall = 1'b0; e.ill = 1'b0;
        if (mHave) begin
            e.pcal = (mPc + 32'd2) & ~32'd3;
            e.stall = 1'b1;
            if (v) begin
                e.instr = {word[15:0], mHalf};
                e.valid = 1'b1;
                e.stall = 1'b0;
            end
        end else begin
            e.pcal = pc & ~32'd3;
            if (v) begin
                p = pc[1] ? word[31:16] : word[15:0];
                if (p[1:0] != 2'b11) begin
                    e.instr = {16'h0, p}; e.comp = 1'b1; e.valid = 1'b1;
                end else if (!pc[1]) begin
                    e.instr = word; e.valid = 1'b1;
                end else begin
                    e.stall = 1'b1;
                    e.pcal  = pc + 32'd2;
                end
            end
        end
        if (k) begin
            e.instr = NOP; e.comp = 1'b0; e.valid = 1'b0; e.stall = 1'b0;
        end
        e.ill = ILL_EN && e.comp && (e.instr[15:0] == 16'h0);
        return e;
    endfunction

    task automatic modelClock(input logic [31:0] pc, input logic [31:0] word,
                              input logic v, input logic k);
        if (k) begin
            mHave = 1'b0; mHalf = 16'h0;
        end else if (mHave) begin
            if (v) mHave = 1'b0;
        end else if (v && pc[1] && word[17:16] == 2'b11) begin
            mHave = 1'b1; mHalf = word[31:16]; mPc = pc;
        end
    endtask

    initial begin
        exp_t        e;
        logic [31:0] rpc, rword;
        logic        rv, rk;

        //              pc            word          v     k     instr         comp  valid stall pc_aligned    ill   chkPcal
        vecs[0]  = '{32'h8000_0000, 32'h0010_0093, 1'b1, 1'b0, 32'h0010_0093, 1'b0, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[1]  = '{32'h8000_0000, 32'h4505_0405, 1'b1, 1'b0, 32'h0000_0405, 1'b1, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[2]  = '{32'h8000_0002, 32'h4505_0405, 1'b1, 1'b0, 32'h0000_4505, 1'b1, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[3]  = '{32'h8000_0006, 32'h0093_0001, 1'b1, 1'b0, NOP,           1'b0, 1'b0, 1'b1, 32'h8000_0008, 1'b0, 1'b1};
        vecs[4]  = '{32'h8000_0006, 32'hABCD_0010, 1'b1, 1'b0, 32'h0010_0093, 1'b0, 1'b1, 1'b0, 32'h8000_0008, 1'b0, 1'b1};
        vecs[5]  = '{32'h8000_0006, 32'h0093_0001, 1'b1, 1'b0, NOP,           1'b0, 1'b0, 1'b1, 32'h8000_0008, 1'b0, 1'b1};
        vecs[6]  = '{32'h8000_0006, 32'h1111_1111, 1'b0, 1'b0, NOP,           1'b0, 1'b0, 1'b1, 32'h8000_0008, 1'b0, 1'b1};
        vecs[7]  = '{32'h8000_0006, 32'h2222_2222, 1'b0, 1'b0, NOP,           1'b0, 1'b0, 1'b1, 32'h8000_0008, 1'b0, 1'b1};
        vecs[8]  = '{32'h8000_0006, 32'h3333_3333, 1'b0, 1'b0, NOP,           1'b0, 1'b0, 1'b1, 32'h8000_0008, 1'b0, 1'b1};
        vecs[9]  = '{32'h8000_0006, 32'hABCD_0010, 1'b1, 1'b0, 32'h0010_0093, 1'b0, 1'b1, 1'b0, 32'h8000_0008, 1'b0, 1'b1};
        vecs[10] = '{32'h8000_0006, 32'h0093_0001, 1'b1, 1'b0, NOP,           1'b0, 1'b0, 1'b1, 32'h8000_0008, 1'b0, 1'b1};
        vecs[11] = '{32'h8000_0006, 32'h0000_0000, 1'b0, 1'b0, NOP,           1'b0, 1'b0, 1'b1, 32'h8000_0008, 1'b0, 1'b1};
        vecs[12] = '{32'h8000_0006, 32'hABCD_0010, 1'b1, 1'b1, NOP,           1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0};
        vecs[13] = '{32'h8000_0100, 32'h00A0_0513, 1'b1, 1'b0, 32'h00A0_0513, 1'b0, 1'b1, 1'b0, 32'h8000_0100, 1'b0, 1'b1};
        vecs[14] = '{32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 32'h8000_0000, ILL_EN, 1'b1};
        vecs[15] = '{32'h8000_0004, 32'h0000_0000, 1'b0, 1'b0, NOP,           1'b0, 1'b0, 1'b0, 32'h8000_0004, 1'b0, 1'b1};
        vecs[16] = '{32'h8000_0006, 32'h0093_0001, 1'b1, 1'b1, NOP,           1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0};
        vecs[17] = '{32'h8000_0010, 32'h0000_0033, 1'b1, 1'b0, 32'h0000_0033, 1'b0, 1'b1, 1'b0, 32'h8000_0010, 1'b0, 1'b1};
        vecs[18] = '{32'hFFFF_FFFE, 32'h0017_0000, 1'b1, 1'b0, NOP,           1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b1};
        vecs[19] = '{32'hFFFF_FFFE, 32'h0000_1297, 1'b1, 1'b0, 32'h1297_0017, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b1};

        rst = 1'b1;
        applyStimulus(32'h8000_0006, 32'h0093_0001, 1'b0, 1'b0);
        checkAll("reset", '{NOP, 1'b0, 1'b0, 1'b0, 32'h8000_0004, 1'b0}, 1'b1);
        nextCycle();
        rst = 1'b0;
        nextCycle();

        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i].pc, vecs[i].word, vecs[i].v, vecs[i].k);
            checkAll($sformatf("vec%0d", i),
                     '{vecs[i].eInstr, vecs[i].eComp, vecs[i].eValid, vecs[i].eStall,
                       vecs[i].ePcal, vecs[i].eIll}, vecs[i].chkPcal);
            nextCycle();
        end

        // Asynchronous reset while a split is pending discards the held half.
        applyStimulus(32'h8000_0006, 32'h0093_0001, 1'b1, 1'b0);
        nextCycle();
        applyStimulus(32'h8000_0006, 32'h0000_0000, 1'b0, 1'b0);
        checkAll("midsplit_wait", '{NOP, 1'b0, 1'b0, 1'b1, 32'h8000_0008, 1'b0}, 1'b1);
        rst = 1'b1;
        applyStimulus(32'h8000_0000, 32'h0000_0033, 1'b1, 1'b0);
        checkAll("midsplit_rst", '{32'h0000_0033, 1'b0, 1'b1, 1'b0, 32'h8000_0000, 1'b0}, 1'b1);
        nextCycle();
        rst = 1'b0;
        nextCycle();

        mHave = 1'b0; mHalf = 16'h0; mPc = 32'h0;
        for (int i = 0; i < 400; i++) begin
            rpc   = {$urandom, 2'b00} | ($urandom_range(0, 1) ? 32'd2 : 32'd0);
            rword = $urandom;
            if ($urandom_range(0, 2) == 0) rword[1:0] = 2'b11;
            if ($urandom_range(0, 2) == 0) rword[17:16] = 2'b11;
            if ($urandom_range(0, 15) == 0) rword = 32'h0;
            rv = ($urandom_range(0, 3) != 0);
            rk = ($urandom_range(0, 19) == 0);
            applyStimulus(rpc, rword, rv, rk);
            e = refModel(rpc, rword, rv, rk);
            checkAll($sformatf("rand%0d", i), e, !rk);
            nextCycle();
            modelClock(rpc, rword, rv, rk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
